fetch_ibuf: RTL and testbench
=============================

# fetch_ibuf

Instruction buffer at the FETCH→DECODE boundary, the transmitting end of the decode input interface (`o_valid`/`o_pc`/`o_fid`/`o_data`/`o_bp_*`).
- Accepts fetched instructions with their branch-prediction fields and stores them in a DEPTH-entry FIFO.
- Tags each accepted instruction with a wrapping 8-bit fetch ID (fid).
- Presents the FIFO head to the decode input registers under a valid/ready handshake.
- Flushes on branch commit override and on snoop refresh. The snoop flush holds for 2 cycles, so it stays aligned with the decode-side 2-cycle refresh.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries. Power of two, 2..16.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `snoop_hit`  in  1  snoop filter refresh request; flushes the buffer.
- `bco_valid`  in  1  branch commit override; flushes the buffer.
- `f_valid`  in  1  fetch presents an instruction.
- `f_ready`  out  1  buffer accepts the instruction this cycle.
- `f_pc`  in  32  instruction PC.
- `f_data`  in  32  instruction word.
- `f_bp_pattern`  in  2  predictor pattern.
- `f_bp_taken`  in  1  predicted taken.
- `f_bp_hit`  in  1  BTB hit.
- `f_bp_target`  in  32  predicted target.
- `d_ready`  in  1  decode consumes the head this cycle.
- `o_valid`  out  1  head entry valid.
- `o_pc`  out  32  head PC.
- `o_fid`  out  8  head fetch ID.
- `o_data`  out  32  head instruction word.
- `o_bp_pattern`  out  2  head predictor pattern.
- `o_bp_taken`  out  1  head predicted taken.
- `o_bp_hit`  out  1  head BTB hit.
- `o_bp_target`  out  32  head predicted target.

## Operation
State:
- `snoop_hit_R`: 1-bit delayed copy of `snoop_hit`.
- Read and write pointers: log2(DEPTH) bits each, wrapping DEPTH-1→0.
- `count`: log2(DEPTH)+1 bits.
- `fid_next`: 8 bits.
- Entry storage.

Flush and handshake:
- `flush = snoop_hit | snoop_hit_R | bco_valid`.
- Enqueue happens when `f_valid & f_ready`, with `f_ready = (count != DEPTH) & ~flush & ~reset`. A full buffer refuses input even when it is dequeuing in the same cycle.
- Dequeue happens when `o_valid & d_ready`, with `o_valid = (count != 0) & ~flush`.

Enqueue and dequeue effects:
- Enqueue writes {pc, data, bp fields, fid_next} at the write pointer, advances the write pointer, and increments `fid_next` (mod 256, wrapping 255→0).
- Dequeue advances the read pointer.
- `count` changes by +1 on enqueue, −1 on dequeue, and is unchanged when both happen.

Flush:
- Sets `count`, the read pointer and the write pointer to 0.
- No enqueue or dequeue occurs in a flush cycle.
- `fid_next` is not reset by flush. Fids stay monotonic across redirects.
- `bco_valid` and snoop flushes coincide harmlessly: the result is one flush, and the snoop hold still spans 2 cycles.

Reset:
- Reset sets `snoop_hit_R`, `count`, both pointers and `fid_next` to 0.
- Entry storage is not reset.

Output values:
- `o_*` data outputs reflect the head entry and are don't-care while `o_valid` = 0.

## Timing
- Output reset values: `o_valid` = 0 and `f_ready` = 0 while `reset` is high. On the first cycle after reset, `f_ready` = 1 and `o_valid` = 0.
- Latency: an instruction enqueued at edge N shows `o_valid` = 1 from edge N (the cycle following) when the buffer was empty. This is one cycle fetch→head.
- Flush: `snoop_hit` high in cycle N forces `o_valid` = 0 and `f_ready` = 0 in cycles N and N+1. `bco_valid` does the same for its cycle only. `f_ready` returns to 1 the following cycle.
- Throughput: 1 instruction per cycle while not full.
- Full: `f_ready` = 0 for the cycle in which `count` = DEPTH.
- Reset asserted mid-operation discards all entries at the next edge.

## Configuration
`FETCH_IBUF_BYPASS_EN`:
- Defined: when `count` = 0, `f_valid` = 1 and there is no flush, the outputs drive the input fields combinationally with `o_fid = fid_next` and `o_valid` = 1.
  - If `d_ready` = 1, the instruction is consumed without being written: `fid_next` increments, and the pointers and `count` are unchanged.
  - If `d_ready` = 0, it is enqueued normally.
  - Latency is 0 cycles.
- Undefined: outputs come only from storage, with 1-cycle latency as in Timing.

## Test plan
- Reset, then enqueue pc=0x1000, 0x1004, 0x1008 with `d_ready` = 0 → `o_valid` = 1 with `o_pc` = 0x1000 and `o_fid` = 0. Raising `d_ready` then yields fids 0, 1, 2 in order over 3 cycles.
- DEPTH=4, fill with 4 entries and `d_ready` = 0 → `f_ready` = 0. One dequeue → `f_ready` = 1 the next cycle; the 5th entry gets fid 4.
- `snoop_hit` pulsed 1 cycle with 3 entries held → `o_valid` and `f_ready` are 0 for 2 cycles, `count` is 0, and the next enqueue gets fid 3.
- `bco_valid` on the same cycle as `f_valid` → the instruction is dropped and `o_valid` = 0 that cycle; `f_ready` = 1 on the next cycle.
- 260 back-to-back enqueue/dequeue → fids wrap 255→0 with no gap.
- With `FETCH_IBUF_BYPASS_EN` and the buffer empty, `f_valid` + `d_ready` → `o_valid` = 1 with `o_pc` = `f_pc` in the same cycle, and `count` stays 0.

Source files
------------

// File: rtl/fetch_ibuf.sv
// Fetch-to-decode instruction buffer: DEPTH-entry FIFO with fetch-ID tagging and flush control.
// Optional same-cycle bypass of an empty buffer is enabled by defining FETCH_IBUF_BYPASS_EN.
module fetch_ibuf #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        snoop_hit,
   input  logic        bco_valid,
   input  logic        f_valid,
   output logic        f_ready,
   input  logic [31:0] f_pc,
   input  logic [31:0] f_data,
   input  logic [1:0]  f_bp_pattern,
   input  logic        f_bp_taken,
   input  logic        f_bp_hit,
   input  logic [31:0] f_bp_target,
   input  logic        d_ready,
   output logic        o_valid,
   output logic [31:0] o_pc,
   output logic [7:0]  o_fid,
   output logic [31:0] o_data,
   output logic [1:0]  o_bp_pattern,
   output logic        o_bp_taken,
   output logic        o_bp_hit,
   output logic [31:0] o_bp_target
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
      logic [1:0]  bp_pattern;
      logic        bp_taken;
      logic        bp_hit;
      logic [31:0] bp_target;
      logic [7:0]  fid;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   entry_t        wr_entry;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic [AW:0]   count_reg;
   logic [7:0]    fid_reg;
   logic          snoop_hit_reg;

   logic flush;
   logic empty;
   logic full;
   logic enq;
   logic deq;
   logic bypass;
   logic bypass_take;

   // The delayed snoop copy stretches a snoop flush to two cycles.
   assign flush = snoop_hit | snoop_hit_reg | bco_valid;
   assign empty = (count_reg == '0);
   assign full  = (count_reg == FULL_COUNT);
   assign head  = mem[rd_ptr_reg];

   assign f_ready  = ~full & ~flush & ~reset;
   assign wr_entry = '{pc: f_pc, data: f_data, bp_pattern: f_bp_pattern, bp_taken: f_bp_taken,
                       bp_hit: f_bp_hit, bp_target: f_bp_target, fid: fid_reg};

`ifdef FETCH_IBUF_BYPASS_EN
   assign bypass      = empty & f_valid & ~flush & ~reset;
   assign bypass_take = bypass & d_ready;
`else
   assign bypass      = 1'b0;
   assign bypass_take = 1'b0;
`endif

   // A bypassed instruction that decode takes immediately never touches storage.
   assign o_valid = (~empty | bypass) & ~flush & ~reset;
   assign enq     = f_valid & f_ready & ~bypass_take;
   assign deq     = o_valid & d_ready & ~empty;

   always_comb begin
      o_pc         = head.pc;
      o_fid        = head.fid;
      o_data       = head.data;
      o_bp_pattern = head.bp_pattern;
      o_bp_taken   = head.bp_taken;
      o_bp_hit     = head.bp_hit;
      o_bp_target  = head.bp_target;
      if (bypass) begin
         o_pc         = wr_entry.pc;
         o_fid        = wr_entry.fid;
         o_data       = wr_entry.data;
         o_bp_pattern = wr_entry.bp_pattern;
         o_bp_taken   = wr_entry.bp_taken;
         o_bp_hit     = wr_entry.bp_hit;
         o_bp_target  = wr_entry.bp_target;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         mem[wr_ptr_reg] <= wr_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         snoop_hit_reg <= 1'b0;
         rd_ptr_reg    <= '0;
         wr_ptr_reg    <= '0;
         count_reg     <= '0;
         fid_reg       <= '0;
      end else begin
         snoop_hit_reg <= snoop_hit;
         if (enq | bypass_take) begin
            fid_reg <= fid_reg + 8'd1;
         end
         // Flush keeps fid_reg so fetch IDs stay monotonic across redirects.
         if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
         end else begin
            if (enq) begin
               wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (deq) begin
               rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + (AW + 1)'(enq) - (AW + 1)'(deq);
         end
      end
   end
endmodule

// File: tb/tb_fetch_ibuf.sv
// Scoreboard bench for fetch_ibuf: directed scenarios followed by randomized traffic.
module tb_fetch_ibuf;
   localparam int DEPTH = 4;
`ifdef FETCH_IBUF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      logic [31:0] target;
      logic [1:0]  pat;
      logic        taken;
      logic        hit;
      logic [7:0]  fid;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        snoop_hit = 1'b0;
   logic        bco_valid = 1'b0;
   logic        f_valid = 1'b0;
   logic        f_ready;
   logic [31:0] f_pc = '0;
   logic [31:0] f_data = '0;
   logic [1:0]  f_bp_pattern = '0;
   logic        f_bp_taken = 1'b0;
   logic        f_bp_hit = 1'b0;
   logic [31:0] f_bp_target = '0;
   logic        d_ready = 1'b0;
   logic        o_valid;
   logic [31:0] o_pc;
   logic [7:0]  o_fid;
   logic [31:0] o_data;
   logic [1:0]  o_bp_pattern;
   logic        o_bp_taken;
   logic        o_bp_hit;
   logic [31:0] o_bp_target;

   fetch_ibuf #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .snoop_hit(snoop_hit), .bco_valid(bco_valid),
      .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc), .f_data(f_data),
      .f_bp_pattern(f_bp_pattern), .f_bp_taken(f_bp_taken), .f_bp_hit(f_bp_hit),
      .f_bp_target(f_bp_target), .d_ready(d_ready), .o_valid(o_valid), .o_pc(o_pc),
      .o_fid(o_fid), .o_data(o_data), .o_bp_pattern(o_bp_pattern), .o_bp_taken(o_bp_taken),
      .o_bp_hit(o_bp_hit), .o_bp_target(o_bp_target)
   );

   always #5 clk = ~clk;

   // Reference model: ordered list of instructions decode should still see.
   ent_t       exp_q[$];
   logic [7:0] fid_m = '0;
   logic       snoop_prev = 1'b0;
   logic       exp_fready = 1'b0;
   logic       exp_ovalid = 1'b0;
   bit         started = 1'b0;
   int         checks = 0;
   int         passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("f_ready", {31'd0, f_ready}, {31'd0, exp_fready});
         chk("o_valid", {31'd0, o_valid}, {31'd0, exp_ovalid});
         if (o_valid === 1'b1 && d_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_output: got pc %h fid %h expected nothing", o_pc, o_fid);
            end else begin
               ent_t e;
               e = exp_q.pop_front();
               chk("o_pc", o_pc, e.pc);
               chk("o_fid", {24'd0, o_fid}, {24'd0, e.fid});
               chk("o_data", o_data, e.data);
               chk("o_bp_target", o_bp_target, e.target);
               chk("o_bp_fields", {28'd0, o_bp_pattern, o_bp_taken, o_bp_hit},
                   {28'd0, e.pat, e.taken, e.hit});
            end
         end
      end
   end

   task automatic step(input logic fv, input logic [31:0] pc, input logic dr,
                       input logic sh, input logic bco, input logic rst);
      logic fl;
      ent_t e;
      @(posedge clk);
      #1;
      reset = rst; f_valid = fv; f_pc = pc; d_ready = dr; snoop_hit = sh; bco_valid = bco;
      f_data = $urandom; f_bp_target = $urandom; f_bp_pattern = 2'($urandom_range(0, 3));
      f_bp_taken = 1'($urandom_range(0, 1)); f_bp_hit = 1'($urandom_range(0, 1));
      fl = sh | snoop_prev | bco;
      if (rst) begin
         exp_fready = 1'b0;
         exp_ovalid = 1'b0;
         exp_q.delete();
         fid_m = '0;
         snoop_prev = 1'b0;
      end else begin
         exp_fready = (exp_q.size() < DEPTH) && !fl;
         exp_ovalid = !fl && (exp_q.size() > 0 || (BYP && fv));
         if (fl) exp_q.delete();
         else if (fv && exp_fready) begin
            e.pc = pc; e.data = f_data; e.target = f_bp_target; e.pat = f_bp_pattern;
            e.taken = f_bp_taken; e.hit = f_bp_hit; e.fid = fid_m;
            exp_q.push_back(e);
            fid_m = fid_m + 8'd1;
         end
         snoop_prev = sh;
      end
      started = 1'b1;
   endtask

   initial begin
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      // Three instructions held, then drained in order.
      for (int i = 0; i < 3; i++) step(1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
      // Fill to DEPTH, a refused fifth, one dequeue, then the fifth accepted.
      for (int i = 0; i < DEPTH; i++) step(1, 32'h2000 + 32'(4 * i), 0, 0, 0, 0);
      step(1, 32'h2010, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(1, 32'h2010, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1, 0, 0, 0);
      // Snoop flush with three held entries.
      for (int i = 0; i < 3; i++) step(1, 32'h3000 + 32'(4 * i), 0, 0, 0, 0);
      step(1, 32'h3100, 1, 1, 0, 0);
      step(1, 32'h3104, 1, 0, 0, 0);
      step(1, 32'h3108, 1, 0, 0, 0);
      // Branch override drops the instruction presented with it.
      step(1, 32'h4000, 1, 0, 1, 0);
      step(1, 32'h4004, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
      // Back-to-back stream long enough to wrap the 8-bit fid.
      for (int i = 0; i < 260; i++) step(1, 32'h5000 + 32'(4 * i), 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
      // Randomized traffic with occasional flushes and resets.
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
              $urandom_range(0, 40) == 0, $urandom_range(0, 50) == 0,
              $urandom_range(0, 300) == 0);
      end
      for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 1, 0, 0, 0);
      @(negedge clk);
      #1;
      started = 1'b0;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
